// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: time-slices NUM_DIGITS digits with an
// anti-ghosting blank at the start of each slot and frame-aligned value updates.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    lz_en,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]         idx_q, idx_d;
  logic [0:0]            st_q, st_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  logic                  slot_end, frame_end, accept, commit;
  logic [3:0]            nib;
  logic                  dig_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign slot_end   = (cnt_q == CNT_LAST);
  assign frame_end  = slot_end && (idx_q == IDX_LAST);
  assign cnt_inc    = cnt_q + CW'(1);
  assign load_ready = !pend_vld_q;

  // accept needs an empty pending slot and commit needs a full one, so they
  // are never true together; a frame-end handshake waits for the next frame.
  assign accept = load_valid && !pend_vld_q;
  assign commit = en && frame_end && pend_vld_q;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    st_d  = st_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
      st_d  = ST_BLANK;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      st_d  = ST_BLANK;
    end else begin
      cnt_d = cnt_inc;
      st_d  = (cnt_inc >= CNT_SHOW) ? ST_SHOW : ST_BLANK;
    end
  end

  always_comb begin
    pend_d     = accept ? load_data : pend_q;
    pend_vld_d = accept ? 1'b1 : (commit ? 1'b0 : pend_vld_q);
    active_d   = commit ? pend_q : active_q;
  end

  // Scan from the top digit down so "all higher nibbles zero" accumulates.
  always_comb begin
    logic hi_zero;
    nib       = 4'h0;
    dig_blank = 1'b0;
    hi_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (active_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        nib       = active_q[4*i +: 4];
        dig_blank = lz_en && hi_zero && (i != 0);
      end
    end
  end

  always_comb begin
    seg_d = 7'b0;
    an_d  = '1;
    fd_d  = en && frame_end;
    if (en && (st_q == ST_SHOW) && !dig_blank) begin
      seg_d = hex7(nib);
      for (int i = 0; i < NUM_DIGITS; i++)
        if (idx_q == IW'(i)) an_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      st_q       <= ST_BLANK;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= 7'b0;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      st_q       <= st_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a small 4-digit, 8-cycle-slot configuration.
module tb_seg_scan_ctrl;
  localparam int ND = 4, RD = 8, BC = 2;

  logic        clk = 1'b0;
  logic        rst, en, lz_en, load_valid, load_ready, frame_done;
  logic [15:0] load_data;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_tests = 0, n_fail = 0, pos = 0;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .lz_en(lz_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto(input int p);
    while (pos < p) tick();
  endtask

  // Leaves pos=0 on the cycle frame_done is seen (scanner back at digit 0, count 0).
  task automatic wait_fd();
    int k;
    k = 0;
    tick();
    while (frame_done !== 1'b1 && k < 80) begin
      tick();
      k++;
    end
    chk("fd_seen", frame_done, 1);
    pos = 0;
  endtask

  task automatic load(input logic [15:0] v);
    load_valid = 1'b1;
    load_data  = v;
    tick();
    load_valid = 1'b0;
  endtask

  // Checks digit d mid-SHOW; lit=0 means it must be dark.
  task automatic dig(input string tag, input int d, input logic [6:0] s, input bit lit);
    logic [3:0] e;
    e = ~(4'b1 << d);
    goto(8 * d + 5);
    chk({tag, "_an"}, an, lit ? e : 4'hF);
    chk({tag, "_seg"}, seg, lit ? s : 7'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, viol;
    rst = 1'b1; en = 1'b1; lz_en = 1'b0; load_valid = 1'b0; load_data = '0;
    tick();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h00);
    chk("rst_rdy", load_ready, 1);
    chk("rst_fd", frame_done, 0);
    rst = 1'b0;
    tick(); chk("c1_an", an, 4'hF);
    tick(); chk("c2_an", an, 4'hF);
    tick(); chk("c3_an", an, 4'hE); chk("c3_seg", seg, 7'h7E);

    // load mid-frame, commit at frame end
    wait_fd();
    goto(5);
    load(16'h12AF);
    chk("ld_rdy", load_ready, 0);
    dig("ld_old1", 1, 7'h7E, 1);
    wait_fd();
    chk("cm_rdy", load_ready, 1);
    dig("cm_d0", 0, 7'h47, 1);
    dig("cm_d1", 1, 7'h77, 1);
    dig("cm_d2", 2, 7'h6D, 1);
    dig("cm_d3", 3, 7'h30, 1);

    // backpressure: second offer while pending is dropped
    wait_fd();
    goto(2);
    load(16'h3456);
    chk("bp_rdy", load_ready, 0);
    goto(4);
    load(16'h9999);
    wait_fd();
    dig("bp_d0", 0, 7'h5F, 1);
    dig("bp_d1", 1, 7'h5B, 1);
    dig("bp_d2", 2, 7'h33, 1);
    dig("bp_d3", 3, 7'h79, 1);

    // leading-zero blanking
    lz_en = 1'b1;
    wait_fd();
    load(16'h0005);
    wait_fd();
    dig("lz5_d0", 0, 7'h5B, 1);
    dig("lz5_d1", 1, 7'h00, 0);
    dig("lz5_d2", 2, 7'h00, 0);
    dig("lz5_d3", 3, 7'h00, 0);
    load(16'h0500);
    wait_fd();
    dig("lz500_d0", 0, 7'h7E, 1);
    dig("lz500_d1", 1, 7'h7E, 1);
    dig("lz500_d2", 2, 7'h5B, 1);
    dig("lz500_d3", 3, 7'h00, 0);
    load(16'h0000);
    wait_fd();
    dig("lz0_d0", 0, 7'h7E, 1);
    dig("lz0_d1", 1, 7'h00, 0);
    lz_en = 1'b0;

    // frame period, pulse width, at most one anode low
    wait_fd();
    per = 0; viol = 0;
    tick(); per++;
    if ($countones(~an) > 1) viol++;
    while (frame_done !== 1'b1 && per < 80) begin
      tick(); per++;
      if ($countones(~an) > 1) viol++;
    end
    chk("fd_period", per, 32);
    chk("an_onehot", viol, 0);
    pos = 0;
    tick();
    chk("fd_width", frame_done, 0);

    // handshake in the frame-end cycle commits one frame later
    goto(31);
    load_valid = 1'b1; load_data = 16'h0007;
    tick();
    load_valid = 1'b0;
    chk("fe_fd", frame_done, 1);
    pos = 0;
    chk("fe_rdy", load_ready, 0);
    dig("fe_old", 0, 7'h7E, 1);
    wait_fd();
    dig("fe_new", 0, 7'h70, 1);

    // enable drop mid-SHOW
    wait_fd();
    dig("en_pre", 0, 7'h70, 1);
    en = 1'b0;
    tick();
    chk("en0_an", an, 4'hF);
    chk("en0_seg", seg, 7'h00);
    load(16'h00C0);
    tick(); tick();
    chk("en0_an2", an, 4'hF);
    chk("en0_fd", frame_done, 0);
    chk("en0_rdy", load_ready, 0);
    en = 1'b1;
    tick(); chk("en1_b0", an, 4'hF);
    tick(); chk("en1_b1", an, 4'hF);
    tick(); chk("en1_an", an, 4'hE); chk("en1_seg", seg, 7'h70);
    wait_fd();
    dig("en_cm_d0", 0, 7'h7E, 1);
    dig("en_cm_d1", 1, 7'h4E, 1);

    // reset discards pending data
    load(16'h8888);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_rdy", load_ready, 1);
    chk("rr_an", an, 4'hF);
    tick(); tick(); tick();
    chk("rr_an3", an, 4'hE);
    chk("rr_seg3", seg, 7'h7E);
    wait_fd();
    dig("rr_d3", 3, 7'h7E, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
